i2s_dac_transmitter: RTL and testbench
======================================

I2S_DAC_TRANSMITTER -- requirements
Module: i2s_dac_transmitter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8, giving clk cycles per SCK half-period; legal range 2..255, so SCK = 3.125 MHz at 50 MHz.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 24, giving audio bits per channel; slot width is fixed at 32.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port sample_l, input, SAMPLE_WIDTH, left sample, two's complement.
REQ-006 SHALL have port sample_r, input, SAMPLE_WIDTH, right sample, two's complement.
REQ-007 SHALL have port sample_valid, input, 1, sample pair offered.
REQ-008 SHALL have port sample_ready, output, 1, holding register empty.
REQ-009 SHALL have port sck, output, 1, I2S bit clock.
REQ-010 SHALL have port ws, output, 1, word select; 0 = left, 1 = right.
REQ-011 SHALL have port sd, output, 1, serial data, MSB first.
REQ-012 SHALL have port frame_start, output, 1, one-clk pulse when a frame is loaded.
REQ-013 SHALL have port underrun, output, 1, one-clk pulse when a frame loads with an empty holding register.

Function
REQ-014 SHALL run a divider div_cnt over 0..CLK_DIV-1 and toggle sck in the cycle where div_cnt==CLK_DIV-1.
REQ-015 SHALL name the cycle where sck toggles 1->0 the "fall event"; ws, sd, bit_cnt and the shift registers SHALL change only at fall events.
REQ-016 SHALL use a 6-bit bit_cnt, 0..63, advanced at each fall event; it SHALL wrap from 63 to 0.
REQ-017 SHALL drive ws as 0 while bit_cnt is 0..31 and 1 while bit_cnt is 32..63, updated with bit_cnt in the same cycle.
REQ-018 SHALL form each 32-bit slot word as {sample, (32-SAMPLE_WIDTH) zeros}.
REQ-019 SHALL delay sd one SCK behind ws (standard I2S): at slot position n = 1..31, sd = slot word bit (31-(n-1)); at position 0, sd = 0.
REQ-020 SHALL, on the fall event where bit_cnt wraps 63->0, load the left and right shift registers from the holding register and pulse frame_start for that cycle.
REQ-021 SHALL, when the holding register is empty at a frame load, reload the previously transmitted pair, pulse underrun, and keep frame_start pulsing.
REQ-022 SHALL treat the holding register as one entry, accepted when sample_valid && sample_ready; sample_ready SHALL deassert the cycle after acceptance.
REQ-023 SHALL reassert sample_ready the cycle after a frame load consumes the entry.
REQ-024 SHALL, when acceptance and frame load coincide, load the shift registers from the old entry and capture the new one; sample_ready SHALL stay 0.
REQ-025 SHALL hold sample_ready at 1 while the entry is empty, whether or not sample_valid is asserted.
REQ-026 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, while rst is high, force sck=0, ws=1, sd=0, sample_ready=1, frame_start=0 and underrun=0.
REQ-028 SHALL, while rst is high, force div_cnt=0, bit_cnt=63, and shift, last and holding registers to 0 with the holding register empty.
REQ-029 SHALL place the first fall event 2*CLK_DIV clk cycles after rst deasserts; it SHALL load frame 0 with ws going 0.
REQ-030 SHALL, when rst is asserted mid-frame, abort the frame within one clk and discard any held sample.

Verification
REQ-031 SHALL check timing with CLK_DIV=8: sck period = 16 clk; ws period = 1024 clk; ws edges align to sck falls.
REQ-032 SHALL check data: sample_l=24'hA5A5A5, sample_r=24'h123456 -> left slot sd = 0,A5A5A5 MSB-first,7 zeros; right slot sd = 0,123456,7 zeros.
REQ-033 SHALL check underrun: one pair sent, then sample_valid held 0 -> next frame repeats the pair; underrun pulses once per frame; frame_start pulses every 64 SCK.
REQ-034 SHALL check backpressure: sample_valid held 1 with changing data -> exactly one acceptance per frame; sample_ready low between accept and load; no pair skipped or duplicated.
REQ-035 SHALL check coincidence: sample_valid rises in the load cycle with the holding register full -> old pair transmitted, new pair held, sample_ready=0.
REQ-036 SHALL check reset mid-right-slot: outputs return to reset values within one clk; the first fall comes 2*CLK_DIV clk after release; the first frame after reset is underrun, sending zeros with underrun=1.

Source files
------------

// File: rtl/i2s_dac_transmitter.sv
// I2S DAC transmitter: 32-bit stereo slots, one-entry holding register, and
// replay of the previous pair when no new pair is waiting at frame load.
module i2s_dac_transmitter #(
    parameter int CLK_DIV      = 8,
    parameter int SAMPLE_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] sample_l,
    input  logic [SAMPLE_WIDTH-1:0] sample_r,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    sck,
    output logic                    ws,
    output logic                    sd,
    output logic                    frame_start,
    output logic                    underrun
);
    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);
    localparam int         PAD     = 32 - SAMPLE_WIDTH;

    logic [7:0]              div_cnt_q, div_cnt_d;
    logic                    sck_q, sck_d;
    logic [5:0]              bit_cnt_q, bit_cnt_d;
    logic                    ws_q, ws_d;
    logic                    sd_q, sd_d;
    logic [31:0]             sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic [SAMPLE_WIDTH-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
    logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic                    hold_full_q, hold_full_d;
    logic                    ready_q, ready_d;
    logic                    frame_start_q, frame_start_d;
    logic                    underrun_q, underrun_d;
    logic [SAMPLE_WIDTH-1:0] src_l, src_r;

    logic tick, fall, load, accept;

    assign tick   = (div_cnt_q == DIV_MAX);
    assign fall   = tick && sck_q;
    assign load   = fall && (bit_cnt_q == 6'd63);
    assign accept = sample_valid && ready_q;

    function automatic logic [31:0] slot_word(input logic [SAMPLE_WIDTH-1:0] s);
        return 32'(s) << PAD;
    endfunction

    always_comb begin
        div_cnt_d     = tick ? 8'd0 : div_cnt_q + 8'd1;
        sck_d         = tick ? ~sck_q : sck_q;
        bit_cnt_d     = bit_cnt_q;
        ws_d          = ws_q;
        sd_d          = sd_q;
        sh_l_d        = sh_l_q;
        sh_r_d        = sh_r_q;
        last_l_d      = last_l_q;
        last_r_d      = last_r_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        hold_full_d   = hold_full_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        src_l         = last_l_q;
        src_r         = last_r_q;

        if (fall) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            ws_d      = bit_cnt_d[5];
            if (load) begin
                // An empty holding register replays the pair last sent.
                if (hold_full_q) begin
                    src_l = hold_l_q;
                    src_r = hold_r_q;
                end
                last_l_d      = src_l;
                last_r_d      = src_r;
                sh_l_d        = slot_word(src_l);
                sh_r_d        = slot_word(src_r);
                sd_d          = 1'b0;
                frame_start_d = 1'b1;
                underrun_d    = ~hold_full_q;
                hold_full_d   = 1'b0;
            end else if (bit_cnt_d[4:0] == 5'd0) begin
                sd_d = 1'b0;
            end else if (bit_cnt_d[5]) begin
                sd_d   = sh_r_q[31];
                sh_r_d = {sh_r_q[30:0], 1'b0};
            end else begin
                sd_d   = sh_l_q[31];
                sh_l_d = {sh_l_q[30:0], 1'b0};
            end
        end

        // Capture after the load so a coincident accept refills the freed entry.
        if (accept) begin
            hold_l_d    = sample_l;
            hold_r_d    = sample_r;
            hold_full_d = 1'b1;
        end
        ready_d = ~hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            sck_q         <= 1'b0;
            bit_cnt_q     <= 6'd63;
            ws_q          <= 1'b1;
            sd_q          <= 1'b0;
            sh_l_q        <= '0;
            sh_r_q        <= '0;
            last_l_q      <= '0;
            last_r_q      <= '0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            hold_full_q   <= 1'b0;
            ready_q       <= 1'b1;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            sck_q         <= sck_d;
            bit_cnt_q     <= bit_cnt_d;
            ws_q          <= ws_d;
            sd_q          <= sd_d;
            sh_l_q        <= sh_l_d;
            sh_r_q        <= sh_r_d;
            last_l_q      <= last_l_d;
            last_r_q      <= last_r_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            hold_full_q   <= hold_full_d;
            ready_q       <= ready_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign sample_ready = ready_q;
    assign sck          = sck_q;
    assign ws           = ws_q;
    assign sd           = sd_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;
endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// Bench for i2s_dac_transmitter: a negedge monitor records each frame's bit
// stream, and a pair-queue model predicts frame contents, underruns and ready.
module tb_i2s_dac_transmitter;
    localparam int SW   = 24;
    localparam int DIV  = 8;
    localparam int MAXF = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] sample_l = '0, sample_r = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready, sck, ws, sd, frame_start, underrun;

    i2s_dac_transmitter #(.CLK_DIV(DIV), .SAMPLE_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .sample_l(sample_l), .sample_r(sample_r),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .sck(sck),
        .ws(ws), .sd(sd), .frame_start(frame_start), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Monitor / reference-model state
    logic [63:0]     obs_sd [MAXF];
    logic [63:0]     obs_ws [MAXF];
    bit              obs_ur [MAXF];
    bit              exp_ur [MAXF];
    logic [2*SW-1:0] exp_pair [MAXF];
    int              fs_cyc [MAXF];
    int              fbits  [MAXF];
    int              acc_cnt[MAXF];
    int              nframes = 0, cyc = 0, rel_cyc = 0, first_fall = -1;
    int              stray_ur = 0, ready_viol = 0, ws_off_fall = 0, cur_acc = 0;
    int              falls[$], ws_rise[$];
    logic [2*SW-1:0] q[$];
    logic [2*SW-1:0] last_pair = '0, acc_pair = '0, pair;
    bit              acc_pend = 0, prev_rst = 1, prev_sck = 0, prev_ws = 1, in_frame = 0;
    int              fcur = 0;

    // Expected frame stream: bit k of result is sd after the k-th fall of the frame.
    function automatic logic [63:0] exp_stream(input logic [2*SW-1:0] p);
        logic [63:0] s;
        logic [31:0] w;
        int n;
        s = '0;
        for (int k = 0; k < 64; k++) begin
            w = (k < 32) ? {p[2*SW-1:SW], 8'h00} : {p[SW-1:0], 8'h00};
            n = k % 32;
            s[k] = (n == 0) ? 1'b0 : w[32-n];
        end
        return s;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            last_pair  = '0;
            acc_pend   = 0;
            in_frame   = 0;
            cur_acc    = 0;
            first_fall = -1;
            falls.delete();
            ws_rise.delete();
            prev_sck = sck;
            prev_ws  = ws;
        end else begin
            if (prev_rst) rel_cyc = cyc;
            if (frame_start && nframes < MAXF) begin
                fcur = nframes;
                nframes++;
                if (q.size() > 0) begin pair = q.pop_front(); exp_ur[fcur] = 0; end
                else begin pair = last_pair; exp_ur[fcur] = 1; end
                last_pair       = pair;
                exp_pair[fcur]  = pair;
                obs_ur[fcur]    = underrun;
                fs_cyc[fcur]    = cyc;
                fbits[fcur]     = 0;
                acc_cnt[fcur]   = cur_acc;
                cur_acc         = 0;
                in_frame        = 1;
                obs_sd[fcur]    = '0;
                obs_ws[fcur]    = '0;
            end else if (underrun) stray_ur++;
            if (acc_pend) begin q.push_back(acc_pair); cur_acc++; end
            acc_pend = sample_valid && sample_ready;
            acc_pair = {sample_l, sample_r};
            if (sample_ready !== (q.size() == 0)) ready_viol++;
            if (prev_sck && !sck) begin
                falls.push_back(cyc);
                if (first_fall < 0) first_fall = cyc;
                if (!prev_ws && ws) ws_rise.push_back(cyc);
                if (in_frame && fbits[fcur] < 64) begin
                    obs_sd[fcur][fbits[fcur]] = sd;
                    obs_ws[fcur][fbits[fcur]] = ws;
                    fbits[fcur]++;
                end
            end else if (ws !== prev_ws) ws_off_fall++;
            prev_sck = sck;
            prev_ws  = ws;
        end
        prev_rst = rst;
    end

    task automatic wait_frames(input int target);
        int t = 0;
        while (nframes < target && t < 80 * 1024) begin @(negedge clk); t++; end
        if (nframes < target) begin
            checks++; errors++;
            $display("FAIL wait_frames: got %0d frames, required %0d", nframes, target);
        end
    endtask

    task automatic send_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
        int t = 0;
        @(posedge clk); #2;
        sample_l = l; sample_r = r; sample_valid = 1'b1;
        while (!sample_ready && t < 3000) begin @(posedge clk); #2; t++; end
        if (!sample_ready) begin
            checks++; errors++;
            $display("FAIL send_pair: sample_ready never asserted");
        end
        @(posedge clk); #2;
        sample_valid = 1'b0;
    endtask

    task automatic test_reset;
        int t = 0;
        sample_valid = 1'b1; sample_l = 24'h111111; sample_r = 24'h222222;
        repeat (4) @(negedge clk);
        checks++; if (sck !== 1'b0)         begin errors++; $display("FAIL reset_sck: got %b want 0", sck); end
        checks++; if (ws !== 1'b1)          begin errors++; $display("FAIL reset_ws: got %b want 1", ws); end
        checks++; if (sd !== 1'b0)          begin errors++; $display("FAIL reset_sd: got %b want 0", sd); end
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", sample_ready); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
        checks++; if (underrun !== 1'b0)    begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        @(posedge clk); #2;
        sample_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        while (first_fall < 0 && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        checks++;
        if (first_fall - rel_cyc !== 2 * DIV) begin
            errors++; $display("FAIL first_fall_delay: got %0d want %0d", first_fall - rel_cyc, 2 * DIV);
        end
        checks++;
        if (nframes !== 1 || fs_cyc[0] !== first_fall) begin
            errors++; $display("FAIL first_frame_load: frames %0d at %0d, want 1 at %0d", nframes, fs_cyc[0], first_fall);
        end
        checks++;
        if (obs_ws[0][0] !== 1'b0 || obs_ur[0] !== 1'b1) begin
            errors++; $display("FAIL first_frame_ws_ur: ws %b ur %b, want 0 1", obs_ws[0][0], obs_ur[0]);
        end
    endtask

    task automatic test_data;
        logic [63:0] want;
        send_pair(24'hA5A5A5, 24'h123456);
        wait_frames(3);
        want = exp_stream({24'hA5A5A5, 24'h123456});
        checks++;
        if (obs_sd[1] !== want) begin errors++; $display("FAIL data_sd: got %h want %h", obs_sd[1], want); end
        checks++;
        if (obs_ws[1] !== 64'hFFFFFFFF_00000000) begin errors++; $display("FAIL data_ws: got %h", obs_ws[1]); end
        checks++;
        if (obs_ur[1] !== 1'b0) begin errors++; $display("FAIL data_underrun: got %b want 0", obs_ur[1]); end
    endtask

    task automatic test_underrun;
        logic [63:0] want;
        wait_frames(5);
        want = exp_stream({24'hA5A5A5, 24'h123456});
        for (int f = 2; f <= 3; f++) begin
            checks++;
            if (obs_sd[f] !== want) begin errors++; $display("FAIL underrun_repeat[%0d]: got %h want %h", f, obs_sd[f], want); end
            checks++;
            if (obs_ur[f] !== 1'b1) begin errors++; $display("FAIL underrun_pulse[%0d]: got %b want 1", f, obs_ur[f]); end
            checks++;
            if (fs_cyc[f] - fs_cyc[f-1] !== 64 * 2 * DIV) begin
                errors++; $display("FAIL frame_period[%0d]: got %0d want %0d", f, fs_cyc[f] - fs_cyc[f-1], 64 * 2 * DIV);
            end
        end
    endtask

    task automatic test_timing;
        int bad = 0;
        for (int i = 1; i < falls.size(); i++) if (falls[i] - falls[i-1] != 2 * DIV) bad++;
        checks++;
        if (bad != 0 || falls.size() < 200) begin
            errors++; $display("FAIL sck_period: %0d bad intervals of %0d falls", bad, falls.size());
        end
        checks++;
        if (ws_rise.size() < 2 || ws_rise[1] - ws_rise[0] != 1024) begin
            errors++; $display("FAIL ws_period: %0d rises, want period 1024", ws_rise.size());
        end
        checks++;
        if (ws_off_fall != 0) begin errors++; $display("FAIL ws_align: got %0d off-fall edges want 0", ws_off_fall); end
    endtask

    task automatic test_back_to_back;
        logic [2*SW-1:0] sent[$];
        int nacc = 0, t = 0, s = -1;
        bit rdy;
        @(posedge clk); #2;
        sample_l = 24'($urandom); sample_r = 24'($urandom); sample_valid = 1'b1;
        while (nacc < 6 && t < 8 * 1024) begin
            rdy = sample_ready;
            @(posedge clk); #2; t++;
            if (rdy) begin
                sent.push_back({sample_l, sample_r});
                if (nacc == 0) s = nframes;
                nacc++;
                if (nacc < 6) begin sample_l = 24'($urandom); sample_r = 24'($urandom); end
                else sample_valid = 1'b0;
            end
        end
        sample_valid = 1'b0;
        checks++;
        if (nacc != 6) begin errors++; $display("FAIL b2b_accepts: got %0d want 6", nacc); end
        if (s < 0) s = nframes;
        wait_frames(s + 7);
        if (obs_ur[s]) s++;
        for (int j = 0; j < 5 && j < sent.size(); j++) begin
            checks++;
            if (obs_sd[s+j] !== exp_stream(sent[j]) || obs_ur[s+j] !== 1'b0) begin
                errors++; $display("FAIL b2b_frame[%0d]: got %h ur %b want %h ur 0", j, obs_sd[s+j], obs_ur[s+j], exp_stream(sent[j]));
            end
        end
        for (int j = 1; j <= 4; j++) begin
            checks++;
            if (acc_cnt[s+j] != 1) begin errors++; $display("FAIL b2b_one_per_frame[%0d]: got %0d want 1", j, acc_cnt[s+j]); end
        end
    endtask

    task automatic test_coincidence;
        logic [SW-1:0] ol, orr, nl, nr;
        int n, fc;
        ol = 24'($urandom); orr = 24'($urandom); nl = 24'($urandom); nr = 24'($urandom);
        wait_frames(nframes + 1);
        send_pair(ol, orr);
        fc = nframes;
        n  = fs_cyc[fc-1] + 64 * 2 * DIV;
        wait (cyc >= n - 2);
        @(posedge clk); #2;
        sample_l = nl; sample_r = nr; sample_valid = 1'b1;
        wait (cyc >= n);
        checks++;
        if (frame_start !== 1'b1 || underrun !== 1'b0 || sample_ready !== 1'b1) begin
            errors++; $display("FAIL coinc_load: fs %b ur %b rdy %b want 1 0 1", frame_start, underrun, sample_ready);
        end
        @(posedge clk); #2;
        sample_valid = 1'b0;
        wait (cyc >= n + 1);
        checks++;
        if (sample_ready !== 1'b0) begin errors++; $display("FAIL coinc_ready: got %b want 0", sample_ready); end
        wait_frames(fc + 3);
        checks++;
        if (obs_sd[fc] !== exp_stream({ol, orr})) begin
            errors++; $display("FAIL coinc_old: got %h want %h", obs_sd[fc], exp_stream({ol, orr}));
        end
        checks++;
        if (obs_sd[fc+1] !== exp_stream({nl, nr}) || obs_ur[fc+1] !== 1'b0) begin
            errors++; $display("FAIL coinc_new: got %h want %h", obs_sd[fc+1], exp_stream({nl, nr}));
        end
    endtask

    task automatic test_reset_mid;
        int f, f0, t = 0;
        f = nframes - 1;
        while (fbits[f] < 36 && t < 2000) begin @(negedge clk); t++; end
        send_pair(24'($urandom), 24'($urandom));
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sck, ws, sd, sample_ready, frame_start, underrun} !== 6'b010100) begin
            errors++; $display("FAIL mid_reset_outputs: got %b want 010100", {sck, ws, sd, sample_ready, frame_start, underrun});
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        f0 = nframes;
        wait_frames(f0 + 2);
        checks++;
        if (first_fall - rel_cyc !== 2 * DIV || fs_cyc[f0] !== first_fall) begin
            errors++; $display("FAIL mid_reset_first_fall: got %0d want %0d", first_fall - rel_cyc, 2 * DIV);
        end
        checks++;
        if (obs_ur[f0] !== 1'b1 || obs_sd[f0] !== 64'h0) begin
            errors++; $display("FAIL mid_reset_frame: ur %b sd %h want 1 0", obs_ur[f0], obs_sd[f0]);
        end
    endtask

    task automatic test_model;
        int bad = 0;
        for (int f = 0; f < nframes - 1; f++) begin
            if (fbits[f] == 64) begin
                if (obs_sd[f] !== exp_stream(exp_pair[f]) || obs_ur[f] !== exp_ur[f] ||
                    obs_ws[f] !== 64'hFFFFFFFF_00000000) bad++;
            end
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL model_frames: got %0d bad frames want 0", bad); end
        checks++;
        if (ready_viol != 0) begin errors++; $display("FAIL model_ready: got %0d cycles wrong want 0", ready_viol); end
        checks++;
        if (stray_ur != 0) begin errors++; $display("FAIL stray_underrun: got %0d want 0", stray_ur); end
    endtask

    initial begin
        test_reset();
        test_data();
        test_underrun();
        test_timing();
        test_back_to_back();
        test_coincidence();
        test_reset_mid();
        test_model();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
